// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus between the ID stage, writeback port and the ALU issue stage.
// Signal prefixes are written from the issue stage's point of view.
interface alu_issue_stage_if #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int CTRL_W  = 3,
  parameter int SHAMT_W = 4
);
  logic               i_flush;
  logic               i_inValid;
  logic               o_inReady;
  logic [REG_AW-1:0]  i_inRs;
  logic [REG_AW-1:0]  i_inRt;
  logic [REG_AW-1:0]  i_inRd;
  logic [DATA_W-1:0]  i_inRsData;
  logic [DATA_W-1:0]  i_inRtData;
  logic [DATA_W-1:0]  i_inImm;
  logic               i_inUseImm;
  logic [CTRL_W-1:0]  i_inAluCtrl;
  logic               i_inBNegate;
  logic [SHAMT_W-1:0] i_inShamt;
  logic               i_wbValid;
  logic [REG_AW-1:0]  i_wbRd;
  logic [DATA_W-1:0]  i_wbData;
  logic               o_outValid;
  logic               i_outReady;
  logic [DATA_W-1:0]  o_a;
  logic [DATA_W-1:0]  o_b;
  logic               o_bNegate;
  logic [CTRL_W-1:0]  o_aluCtrl;
  logic [SHAMT_W-1:0] o_shamt;
  logic [REG_AW-1:0]  o_outRd;

  modport slave (
    input  i_flush, i_inValid, i_inRs, i_inRt, i_inRd, i_inRsData, i_inRtData,
           i_inImm, i_inUseImm, i_inAluCtrl, i_inBNegate, i_inShamt,
           i_wbValid, i_wbRd, i_wbData, i_outReady,
    output o_inReady, o_outValid, o_a, o_b, o_bNegate, o_aluCtrl, o_shamt, o_outRd
  );

  modport master (
    output i_flush, i_inValid, i_inRs, i_inRt, i_inRd, i_inRsData, i_inRtData,
           i_inImm, i_inUseImm, i_inAluCtrl, i_inBNegate, i_inShamt,
           i_wbValid, i_wbRd, i_wbData, i_outReady,
    input  o_inReady, o_outValid, o_a, o_b, o_bNegate, o_aluCtrl, o_shamt, o_outRd
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX operand issue stage: two-entry skid buffer with valid/ready handshake,
// writeback bypass at capture and writeback snooping of held entries.
module alu_issue_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int CTRL_W  = 3,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic               useImm;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [CTRL_W-1:0]  aluCtrl;
    logic               bNegate;
    logic [SHAMT_W-1:0] shamt;
    logic [REG_AW-1:0]  rd;
  } entry_t;

  state_t r_state;
  logic   r_outValid;
  logic   r_inReady;
  entry_t r_out;
  entry_t r_skid;

  logic              w_accept;
  logic              w_retire;
  logic              w_wbHit;
  logic [DATA_W-1:0] w_rtOperand;
  entry_t            w_capture;
  entry_t            w_outSnoop;
  entry_t            w_skidSnoop;

  assign w_accept = bus.i_inValid & r_inReady;
  assign w_retire = r_outValid & bus.i_outReady;
  assign w_wbHit  = bus.i_wbValid & (bus.i_wbRd != '0);

  // R0 reads as zero; a nonzero writeback to the same index this cycle wins over the RF read.
  always_comb begin
    w_capture         = '0;
    w_capture.rs      = bus.i_inRs;
    w_capture.rt      = bus.i_inRt;
    w_capture.useImm  = bus.i_inUseImm;
    w_capture.aluCtrl = bus.i_inAluCtrl;
    w_capture.bNegate = bus.i_inBNegate;
    w_capture.shamt   = bus.i_inShamt;
    w_capture.rd      = bus.i_inRd;

    if (bus.i_inRs == '0)
      w_capture.a = '0;
    else if (w_wbHit && (bus.i_wbRd == bus.i_inRs))
      w_capture.a = bus.i_wbData;
    else
      w_capture.a = bus.i_inRsData;

    if (bus.i_inRt == '0)
      w_rtOperand = '0;
    else if (w_wbHit && (bus.i_wbRd == bus.i_inRt))
      w_rtOperand = bus.i_wbData;
    else
      w_rtOperand = bus.i_inRtData;

    w_capture.b = bus.i_inUseImm ? bus.i_inImm : w_rtOperand;

    w_outSnoop = r_out;
    if (w_wbHit && (r_out.rs == bus.i_wbRd))
      w_outSnoop.a = bus.i_wbData;
    if (w_wbHit && !r_out.useImm && (r_out.rt == bus.i_wbRd))
      w_outSnoop.b = bus.i_wbData;

    w_skidSnoop = r_skid;
    if (w_wbHit && (r_skid.rs == bus.i_wbRd))
      w_skidSnoop.a = bus.i_wbData;
    if (w_wbHit && !r_skid.useImm && (r_skid.rt == bus.i_wbRd))
      w_skidSnoop.b = bus.i_wbData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b0;
      r_out      <= '0;
      r_skid     <= '0;
    end else if (bus.i_flush) begin
      r_state    <= EMPTY;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
    end else begin
      r_out  <= w_outSnoop;
      r_skid <= w_skidSnoop;
      case (r_state)
        EMPTY: begin
          r_inReady <= 1'b1;
          if (w_accept) begin
            r_out      <= w_capture;
            r_outValid <= 1'b1;
            r_state    <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_retire) begin
            r_out <= w_capture;
          end else if (w_accept) begin
            r_skid    <= w_capture;
            r_inReady <= 1'b0;
            r_state   <= TWO;
          end else if (w_retire) begin
            r_outValid <= 1'b0;
            r_state    <= EMPTY;
          end
        end
        TWO: begin
          // No accept is possible here because InReady is low while the skid is full.
          if (w_retire) begin
            r_out     <= w_skidSnoop;
            r_inReady <= 1'b1;
            r_state   <= ONE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= EMPTY;
        end
      endcase
    end
  end

  assign bus.o_inReady  = r_inReady;
  assign bus.o_outValid = r_outValid;
  assign bus.o_a        = r_out.a;
  assign bus.o_b        = r_out.b;
  assign bus.o_bNegate  = r_out.bNegate;
  assign bus.o_aluCtrl  = r_out.aluCtrl;
  assign bus.o_shamt    = r_out.shamt;
  assign bus.o_outRd    = r_out.rd;

endmodule
